// File: rtl/pipeline_stream_pkg.sv
// pipeline_stream_pkg
//   Shared state encodings for the pipeline stream controller.
//   issue_state_t : issue-side 4-phase handshake toward the pipeline input
//   acc_state_t   : accept-side 4-phase handshake from the pipeline output
package pipeline_stream_pkg;

    typedef enum logic [1:0] {
        ISSUE_IDLE,
        ISSUE_REQ,
        ISSUE_RELEASE
    } issue_state_t;

    typedef enum logic {
        ACC_WAIT,
        ACC_ACK
    } acc_state_t;

endpackage

// File: rtl/stream_fifo.sv
// stream_fifo
//   Small synchronous FIFO holding pipeline results until the consumer pops.
//   The head entry is read straight from the storage registers, so it is
//   valid in the cycle after the write edge.
// Ports:
//   clk, reset_n   clock / asynchronous active-low reset (pointers and count)
//   push, push_data write one entry (ignored when full)
//   pop            remove head entry (ignored when empty)
//   flush          discard all entries; takes priority over push and pop
//   count          number of stored entries
//   head           oldest entry (undefined when count is 0)
module stream_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [CW-1:0]         count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_stream_ctrl.sv
// pipeline_stream_ctrl
//   Issues a strided stream of fetch addresses into the pipeline input
//   handshake and collects pipeline results into an output FIFO. Issues are
//   limited by MAX_OUTSTANDING and by FIFO credit (outstanding + queued
//   results never exceed OUT_DEPTH). A redirect restarts the stream at
//   redirect_pc, flushes the FIFO and drops every result still in flight.
// Ports:
//   clk, reset_n          clock / asynchronous active-low reset
//   enable                permits new issues
//   redirect_valid/_pc    one-cycle redirect and its new start address
//   pipe_dir/pipe_data_in request and address toward the pipeline
//   pipe_ack_from         pipeline accepted the request
//   pipe_dor/pipe_data_out pipeline result handshake and data
//   pipe_ack_to           result accepted
//   out_valid/out_data/out_ready  FIFO head toward the consumer
//   pc                    next address to issue
//   outstanding           requests issued and not yet returned
module pipeline_stream_ctrl
    import pipeline_stream_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    STRIDE          = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
    parameter int                    MAX_OUTSTANDING = 4,
    parameter int                    OUT_DEPTH       = 4
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   enable,
    input  logic                                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]                  redirect_pc,
    output logic                                   pipe_dir,
    output logic [ADDR_WIDTH-1:0]                  pipe_data_in,
    input  logic                                   pipe_ack_from,
    input  logic                                   pipe_dor,
    input  logic [DATA_WIDTH-1:0]                  pipe_data_out,
    output logic                                   pipe_ack_to,
    output logic                                   out_valid,
    output logic [DATA_WIDTH-1:0]                  out_data,
    input  logic                                   out_ready,
    output logic [ADDR_WIDTH-1:0]                  pc,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(OUT_DEPTH + 1);
    localparam int DW = $clog2(MAX_OUTSTANDING + 2);

    issue_state_t          issue_state, issue_state_d;
    acc_state_t            acc_state, acc_state_d;
    logic                  pipe_dir_d;
    logic [ADDR_WIDTH-1:0] pipe_data_in_d;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic                  req_stale, req_stale_d;
    logic [OW-1:0]         outstanding_d;
    logic [DW-1:0]         drop_cnt, drop_cnt_d;
    logic                  pipe_ack_to_d;

    logic                  can_issue;
    logic                  issue_ack;
    logic                  capture;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [FW-1:0]         fifo_count;

    assign issue_ack = (issue_state == ISSUE_REQ) && pipe_ack_from;
    assign capture   = (acc_state == ACC_WAIT) && pipe_dor;
    assign out_valid = (fifo_count != '0);
    assign fifo_pop  = out_valid && out_ready;

    // Credit rule: every in-flight request owns a FIFO slot, so a returning
    // result always finds room.
    assign can_issue = enable && !redirect_valid
                       && (int'(outstanding) < MAX_OUTSTANDING)
                       && (int'(outstanding) + int'(fifo_count) < OUT_DEPTH);

    // Issue FSM next state. req_stale marks a request that was pending when
    // a redirect arrived: its ack must not advance the already-redirected pc.
    always_comb begin
        issue_state_d  = issue_state;
        pipe_dir_d     = pipe_dir;
        pipe_data_in_d = pipe_data_in;
        pc_d           = pc;
        req_stale_d    = req_stale;
        case (issue_state)
            ISSUE_IDLE: begin
                if (can_issue) begin
                    issue_state_d  = ISSUE_REQ;
                    pipe_dir_d     = 1'b1;
                    pipe_data_in_d = pc;
                end
            end
            ISSUE_REQ: begin
                if (pipe_ack_from) begin
                    issue_state_d = ISSUE_RELEASE;
                    pipe_dir_d    = 1'b0;
                    req_stale_d   = 1'b0;
                    if (!req_stale) pc_d = pc + ADDR_WIDTH'(STRIDE);
                end else if (redirect_valid) begin
                    req_stale_d = 1'b1;
                end
            end
            ISSUE_RELEASE: begin
                if (!pipe_ack_from) issue_state_d = ISSUE_IDLE;
            end
            default: issue_state_d = ISSUE_IDLE;
        endcase
        if (redirect_valid) pc_d = redirect_pc;
    end

    // Accept FSM next state.
    always_comb begin
        acc_state_d   = acc_state;
        pipe_ack_to_d = pipe_ack_to;
        case (acc_state)
            ACC_WAIT: begin
                if (pipe_dor) begin
                    acc_state_d   = ACC_ACK;
                    pipe_ack_to_d = 1'b1;
                end
            end
            ACC_ACK: begin
                if (!pipe_dor) begin
                    acc_state_d   = ACC_WAIT;
                    pipe_ack_to_d = 1'b0;
                end
            end
            default: acc_state_d = ACC_WAIT;
        endcase
    end

    // In-flight count, drop accounting and FIFO write decision.
    always_comb begin
        case ({issue_ack, capture})
            2'b10:   outstanding_d = outstanding + OW'(1);
            2'b01:   outstanding_d = outstanding - OW'(1);
            default: outstanding_d = outstanding;
        endcase

        drop_cnt_d = drop_cnt;
        fifo_push  = 1'b0;
        if (redirect_valid) begin
            // Everything still in flight after this edge is stale, including
            // a request that the pipeline has not yet accepted.
            drop_cnt_d = DW'(outstanding_d)
                       + DW'((issue_state == ISSUE_REQ) && !pipe_ack_from);
        end else if (capture) begin
            if (drop_cnt != '0) drop_cnt_d = drop_cnt - DW'(1);
            else                fifo_push  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_state  <= ISSUE_IDLE;
            acc_state    <= ACC_WAIT;
            pipe_dir     <= 1'b0;
            pipe_data_in <= '0;
            pc           <= RESET_PC;
            req_stale    <= 1'b0;
            outstanding  <= '0;
            drop_cnt     <= '0;
            pipe_ack_to  <= 1'b0;
        end else begin
            issue_state  <= issue_state_d;
            acc_state    <= acc_state_d;
            pipe_dir     <= pipe_dir_d;
            pipe_data_in <= pipe_data_in_d;
            pc           <= pc_d;
            req_stale    <= req_stale_d;
            outstanding  <= outstanding_d;
            drop_cnt     <= drop_cnt_d;
            pipe_ack_to  <= pipe_ack_to_d;
        end
    end

    stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (pipe_data_out),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .head      (out_data)
    );

endmodule

// File: tb/tb_pipeline_stream_ctrl.sv
// tb_pipeline_stream_ctrl
//   Directed bench for pipeline_stream_ctrl. A behavioural pipeline acks each
//   request one cycle after pipe_dir and returns addr+1 at least three cycles
//   later. A second instance with MAX_OUTSTANDING=2 and a silent result side
//   exercises the in-flight limit.
module tb_pipeline_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        pipe_dir;
    logic [31:0] pipe_data_in;
    logic        pipe_ack_from;
    logic        pipe_dor;
    logic [31:0] pipe_data_out;
    logic        pipe_ack_to;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic [31:0] pc;
    logic [2:0]  outstanding;

    logic        enable2 = 1'b0;
    logic        pipe_dir2;
    logic [31:0] pipe_data_in2;
    logic        pipe_ack_from2;
    logic        pipe_ack_to2;
    logic        out_valid2;
    logic [31:0] out_data2;
    logic [31:0] pc2;
    logic [1:0]  outstanding2;

    // pipeline model controls (written by the test, read by the model)
    int          ack_limit = 1000;
    bit          dor_en = 1'b0;
    bit          dor_hold = 1'b0;
    // pipeline model state
    int          cyc;
    int          issue_cnt;
    int          issue2_cnt;
    int          dor_phase;
    logic [31:0] q_addr[$];
    int          q_time[$];
    logic [31:0] addr2 [4];

    int          checks = 0;
    int          passed = 0;
    int          n;

    always #5 clk = ~clk;

    pipeline_stream_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pipe_dir       (pipe_dir),
        .pipe_data_in   (pipe_data_in),
        .pipe_ack_from  (pipe_ack_from),
        .pipe_dor       (pipe_dor),
        .pipe_data_out  (pipe_data_out),
        .pipe_ack_to    (pipe_ack_to),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .pc             (pc),
        .outstanding    (outstanding)
    );

    pipeline_stream_ctrl #(.MAX_OUTSTANDING(2)) dut2 (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .pipe_dir       (pipe_dir2),
        .pipe_data_in   (pipe_data_in2),
        .pipe_ack_from  (pipe_ack_from2),
        .pipe_dor       (1'b0),
        .pipe_data_out  (32'h0),
        .pipe_ack_to    (pipe_ack_to2),
        .out_valid      (out_valid2),
        .out_data       (out_data2),
        .out_ready      (1'b1),
        .pc             (pc2),
        .outstanding    (outstanding2)
    );

    // Pipeline model: reacts 1 time unit after each rising edge.
    initial begin
        pipe_ack_from = 1'b0; pipe_dor = 1'b0; pipe_data_out = '0;
        pipe_ack_from2 = 1'b0;
        cyc = 0; issue_cnt = 0; issue2_cnt = 0; dor_phase = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!reset_n) begin
                pipe_ack_from = 1'b0; pipe_dor = 1'b0; dor_phase = 0;
                q_addr.delete(); q_time.delete(); issue_cnt = 0;
                pipe_ack_from2 = 1'b0; issue2_cnt = 0;
            end else begin
                if (!pipe_ack_from && pipe_dir && issue_cnt < ack_limit) begin
                    pipe_ack_from = 1'b1;
                    q_addr.push_back(pipe_data_in);
                    q_time.push_back(cyc);
                    issue_cnt++;
                end else if (pipe_ack_from && !pipe_dir) begin
                    pipe_ack_from = 1'b0;
                end
                case (dor_phase)
                    0: if (dor_en && q_addr.size() > 0 && cyc - q_time[0] >= 3) begin
                        pipe_data_out = q_addr[0] + 32'd1;
                        void'(q_addr.pop_front());
                        void'(q_time.pop_front());
                        pipe_dor = 1'b1;
                        dor_phase = 1;
                    end
                    1: if (pipe_ack_to && !dor_hold) begin
                        pipe_dor = 1'b0;
                        dor_phase = 2;
                    end
                    default: if (!pipe_ack_to) dor_phase = 0;
                endcase
                if (!pipe_ack_from2 && pipe_dir2) begin
                    pipe_ack_from2 = 1'b1;
                    if (issue2_cnt < 4) addr2[issue2_cnt] = pipe_data_in2;
                    issue2_cnt++;
                end else if (pipe_ack_from2 && !pipe_dir2) begin
                    pipe_ack_from2 = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        enable = 1'b0; enable2 = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        out_ready = 1'b0; dor_en = 1'b0; dor_hold = 1'b0; ack_limit = 1000;
        @(negedge clk); reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (pipe_dir !== 1'b0) $display("FAIL reset_pipe_dir: got %b expected 0", pipe_dir); else passed++;
        checks++; if (pipe_data_in !== 32'h0) $display("FAIL reset_pipe_data_in: got %h expected 0", pipe_data_in); else passed++;
        checks++; if (pipe_ack_to !== 1'b0) $display("FAIL reset_pipe_ack_to: got %b expected 0", pipe_ack_to); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h expected 0", pc); else passed++;
        checks++; if (outstanding !== 3'd0) $display("FAIL reset_outstanding: got %0d expected 0", outstanding); else passed++;
        checks++; if (pipe_ack_to2 !== 1'b0 || out_valid2 !== 1'b0) $display("FAIL reset_dut2_outputs: got ack_to=%b out_valid=%b expected 0 0", pipe_ack_to2, out_valid2); else passed++;
    endtask

    task automatic test_single_stream();
        logic [31:0] exp_data [4];
        exp_data[0] = 32'd1; exp_data[1] = 32'd5; exp_data[2] = 32'd9; exp_data[3] = 32'd13;
        do_reset();
        enable = 1'b1; dor_en = 1'b1;
        @(negedge clk);
        checks++; if (pipe_dir !== 1'b1 || pipe_data_in !== 32'h0) $display("FAIL first_issue: got dir=%b addr=%h expected 1 0", pipe_dir, pipe_data_in); else passed++;
        n = 0;
        while (!(issue_cnt == 4 && outstanding == 3'd0 && dor_phase == 0) && n < 300) begin @(negedge clk); n++; end
        checks++; if (!(issue_cnt == 4 && outstanding == 3'd0)) $display("FAIL stream_drain: got issues=%0d outstanding=%0d expected 4 0", issue_cnt, outstanding); else passed++;
        repeat (5) @(negedge clk);
        checks++; if (pc !== 32'd16) $display("FAIL stream_pc: got %h expected 10", pc); else passed++;
        enable = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp_data[i]) $display("FAIL stream_data%0d: got valid=%b data=%h expected 1 %h", i, out_valid, out_data, exp_data[i]); else passed++;
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL stream_empty: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_outstanding_limit();
        do_reset();
        enable2 = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (issue2_cnt != 2) $display("FAIL limit_issues: got %0d expected 2", issue2_cnt); else passed++;
        checks++; if (addr2[0] !== 32'h0 || addr2[1] !== 32'h4) $display("FAIL limit_addrs: got %h %h expected 0 4", addr2[0], addr2[1]); else passed++;
        checks++; if (outstanding2 !== 2'd2) $display("FAIL limit_outstanding: got %0d expected 2", outstanding2); else passed++;
        checks++; if (pipe_dir2 !== 1'b0 || pc2 !== 32'h8) $display("FAIL limit_idle: got dir=%b pc=%h expected 0 8", pipe_dir2, pc2); else passed++;
        enable2 = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        enable = 1'b1; dor_en = 1'b1;
        repeat (80) @(negedge clk);
        checks++; if (issue_cnt != 4 || pipe_dir !== 1'b0) $display("FAIL bp_full: got issues=%0d dir=%b expected 4 0", issue_cnt, pipe_dir); else passed++;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'd1 || outstanding !== 3'd0) $display("FAIL bp_head: got valid=%b data=%h out=%0d expected 1 1 0", out_valid, out_data, outstanding); else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_data !== 32'd5) $display("FAIL bp_pop: got %h expected 5", out_data); else passed++;
        repeat (80) @(negedge clk);
        checks++; if (issue_cnt != 5 || pipe_dir !== 1'b0) $display("FAIL bp_one_more: got issues=%0d dir=%b expected 5 0", issue_cnt, pipe_dir); else passed++;
        checks++; if (pc !== 32'd20 || out_data !== 32'd5) $display("FAIL bp_state: got pc=%h head=%h expected 14 5", pc, out_data); else passed++;
    endtask

    task automatic test_redirect();
        do_reset();
        ack_limit = 2; enable = 1'b1;
        n = 0;
        while (!(pipe_dir === 1'b1 && pipe_data_in == 32'h8 && issue_cnt == 2) && n < 100) begin @(negedge clk); n++; end
        checks++; if (!(pipe_dir === 1'b1 && pipe_data_in == 32'h8) || outstanding !== 3'd2) $display("FAIL redir_setup: got dir=%b addr=%h out=%0d expected 1 8 2", pipe_dir, pipe_data_in, outstanding); else passed++;
        redirect_valid = 1'b1; redirect_pc = 32'h100; enable = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (pc !== 32'h100 || out_valid !== 1'b0) $display("FAIL redir_effect: got pc=%h valid=%b expected 100 0", pc, out_valid); else passed++;
        checks++; if (pipe_dir !== 1'b1 || pipe_data_in !== 32'h8) $display("FAIL redir_req_held: got dir=%b addr=%h expected 1 8", pipe_dir, pipe_data_in); else passed++;
        ack_limit = 1000; dor_en = 1'b1;
        n = 0;
        while (pipe_dir !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        checks++; if (pipe_dir !== 1'b0 || pc !== 32'h100) $display("FAIL redir_stale_ack: got dir=%b pc=%h expected 0 100", pipe_dir, pc); else passed++;
        enable = 1'b1;
        n = 0;
        while (pipe_dir !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        enable = 1'b0;
        checks++; if (pipe_dir !== 1'b1 || pipe_data_in !== 32'h100) $display("FAIL redir_new_issue: got dir=%b addr=%h expected 1 100", pipe_dir, pipe_data_in); else passed++;
        n = 0;
        while (pipe_dir !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        checks++; if (pc !== 32'h104) $display("FAIL redir_pc_next: got %h expected 104", pc); else passed++;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h101) $display("FAIL redir_first_result: got valid=%b data=%h expected 1 101", out_valid, out_data); else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (out_valid !== 1'b0 || outstanding !== 3'd0) $display("FAIL redir_no_extra: got valid=%b out=%0d expected 0 0", out_valid, outstanding); else passed++;
    endtask

    task automatic test_capture_redirect();
        do_reset();
        enable = 1'b1;
        n = 0;
        while (issue_cnt < 2 && n < 100) begin @(negedge clk); n++; end
        enable = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (outstanding !== 3'd2 || pipe_dir !== 1'b0) $display("FAIL capredir_setup: got out=%0d dir=%b expected 2 0", outstanding, pipe_dir); else passed++;
        dor_en = 1'b1;
        n = 0;
        while (pipe_dor !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (pc !== 32'h200 || outstanding !== 3'd1 || pipe_ack_to !== 1'b1) $display("FAIL capredir_edge: got pc=%h out=%0d ack_to=%b expected 200 1 1", pc, outstanding, pipe_ack_to); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL capredir_no_write: got %b expected 0", out_valid); else passed++;
        n = 0;
        while (outstanding !== 3'd0 && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        checks++; if (out_valid !== 1'b0 || outstanding !== 3'd0) $display("FAIL capredir_second_dropped: got valid=%b out=%0d expected 0 0", out_valid, outstanding); else passed++;
        enable = 1'b1;
        n = 0;
        while (pipe_dir !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        enable = 1'b0;
        checks++; if (pipe_data_in !== 32'h200) $display("FAIL capredir_issue: got %h expected 200", pipe_data_in); else passed++;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h201) $display("FAIL capredir_result: got valid=%b data=%h expected 1 201", out_valid, out_data); else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        ack_limit = 1; dor_en = 1'b1; dor_hold = 1'b1; enable = 1'b1;
        n = 0;
        while (!(pipe_dir === 1'b1 && pipe_ack_to === 1'b1) && n < 100) begin @(negedge clk); n++; end
        checks++; if (pipe_dir !== 1'b1 || pipe_ack_to !== 1'b1 || out_valid !== 1'b1 || pc !== 32'h4) $display("FAIL areset_setup: got dir=%b ack_to=%b valid=%b pc=%h expected 1 1 1 4", pipe_dir, pipe_ack_to, out_valid, pc); else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (pipe_dir !== 1'b0 || pipe_ack_to !== 1'b0 || out_valid !== 1'b0) $display("FAIL areset_outputs: got dir=%b ack_to=%b valid=%b expected 0 0 0", pipe_dir, pipe_ack_to, out_valid); else passed++;
        checks++; if (pc !== 32'h0 || outstanding !== 3'd0 || pipe_data_in !== 32'h0) $display("FAIL areset_state: got pc=%h out=%0d addr=%h expected 0 0 0", pc, outstanding, pipe_data_in); else passed++;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        enable = 1'b0; dor_en = 1'b0; dor_hold = 1'b0; ack_limit = 1000;
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_outstanding_limit();
        test_backpressure();
        test_redirect();
        test_capture_redirect();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
